zeroskip_pipe: RTL and testbench

Pipelined, flow-controlled zero-skip compactor for the activation path. Each accepted group of `GROUP_SIZE` activations is packed into at most `GROUP_NZ_MAX` slots, keeping only the entries flagged nonzero, in ascending source order. Alongside each packed activation it emits the original source index, which the PE array uses to fetch matching weights. It sits between the activation fetch buffer and the sparse PE array and replaces the purely combinational compactor. It adds a valid/ready handshake, a runtime sparsity mode, overflow detection and an overflow statistics counter.

---
 rtl/zeroskip_pipe.sv | 127 ++++++++++++
 tb/tb_zeroskip_pipe.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/zeroskip_pipe.sv
// Two-stage elastic zero-skip compactor: S1 captures a group plus its prefix counts,
// S2 scatters the kept activations into ascending slots and tracks overflow.
module zeroskip_pipe #(
  parameter int GROUP_SIZE   = 32,
  parameter int GROUP_NZ_MAX = 16,
  parameter int DATA_W       = 8,
  parameter int IDX_W        = $clog2(GROUP_SIZE),
  parameter int CNT_W        = $clog2(GROUP_NZ_MAX + 1)
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     mode,
  input  logic                                     in_valid,
  output logic                                     in_ready,
  input  logic [GROUP_SIZE-1:0]                    znz_din,
  input  logic [GROUP_SIZE-1:0][DATA_W-1:0]        act_din,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [GROUP_NZ_MAX-1:0][DATA_W-1:0]      act_enc_dout,
  output logic [GROUP_NZ_MAX-1:0][IDX_W-1:0]       idx_enc_dout,
  output logic [CNT_W-1:0]                         nz_cnt,
  output logic                                     ovf,
  input  logic                                     ovf_cnt_clr,
  output logic [15:0]                              ovf_cnt
);

  localparam int SLOT_W = $clog2(GROUP_NZ_MAX);
  localparam int PC_W   = IDX_W + 1;
  typedef logic [PC_W-1:0] pc_t;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  function automatic pc_t clip_cnt(input pc_t v, input pc_t lim);
    return (v > lim) ? lim : v;
  endfunction

  logic                                 vld_p1_q, vld_p1_d, vld_p2_q, vld_p2_d;
  logic                                 mode_p1_q, mode_p1_d;
  logic [GROUP_SIZE-1:0]                mask_p1_q, mask_p1_d;
  logic [GROUP_SIZE-1:0][DATA_W-1:0]    act_p1_q, act_p1_d;
  logic [GROUP_SIZE-1:0][IDX_W-1:0]     pos_p1_q, pos_p1_d, pos_new;
  logic [GROUP_NZ_MAX-1:0][DATA_W-1:0]  act_enc_q, act_enc_d, act_cmp;
  logic [GROUP_NZ_MAX-1:0][IDX_W-1:0]   idx_enc_q, idx_enc_d, idx_cmp;
  logic [CNT_W-1:0]                     nz_cnt_q, nz_cnt_d;
  logic                                 ovf_q, ovf_d;
  logic [15:0]                          ovf_cnt_q, ovf_cnt_d;
  logic                                 s1_load, s2_load, ovf_xfer;
  pc_t                                  run_c, lim, popcnt;

  assign s2_load  = vld_p1_q & (~vld_p2_q | out_ready);
  assign in_ready = ~vld_p1_q | s2_load;
  assign s1_load  = in_valid & in_ready;
  assign ovf_xfer = vld_p2_q & out_ready & ovf_q;

  // Stage 1: capture the group and the number of kept entries below each position
  always_comb begin
    run_c = '0;
    pos_new = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      pos_new[i] = run_c[IDX_W-1:0];
      run_c      = run_c + pc_t'(znz_din[i]);
    end
    vld_p1_d  = s1_load ? 1'b1 : (s2_load ? 1'b0 : vld_p1_q);
    mode_p1_d = s1_load ? mode    : mode_p1_q;
    mask_p1_d = s1_load ? znz_din : mask_p1_q;
    act_p1_d  = s1_load ? act_din : act_p1_q;
    pos_p1_d  = s1_load ? pos_new : pos_p1_q;
  end

  // Stage 2: scatter kept entries to their prefix slot, clip at the mode limit
  always_comb begin
    lim     = mode_p1_q ? pc_t'(GROUP_NZ_MAX / 2) : pc_t'(GROUP_NZ_MAX);
    popcnt  = pc_t'(pos_p1_q[GROUP_SIZE-1]) + pc_t'(mask_p1_q[GROUP_SIZE-1]);
    act_cmp = '0;
    idx_cmp = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      if (mask_p1_q[i] && (pc_t'(pos_p1_q[i]) < lim)) begin
        act_cmp[pos_p1_q[i][SLOT_W-1:0]] = act_p1_q[i];
        idx_cmp[pos_p1_q[i][SLOT_W-1:0]] = IDX_W'(i);
      end
    end
    vld_p2_d  = s2_load ? 1'b1 : (out_ready ? 1'b0 : vld_p2_q);
    act_enc_d = s2_load ? act_cmp : act_enc_q;
    idx_enc_d = s2_load ? idx_cmp : idx_enc_q;
    nz_cnt_d  = s2_load ? CNT_W'(clip_cnt(popcnt, lim)) : nz_cnt_q;
    ovf_d     = s2_load ? (popcnt > lim) : ovf_q;
    ovf_cnt_d = ovf_cnt_clr ? 16'd0 : (ovf_xfer ? sat_inc(ovf_cnt_q) : ovf_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      act_enc_q <= '0;
      idx_enc_q <= '0;
      nz_cnt_q  <= '0;
      ovf_q     <= 1'b0;
      ovf_cnt_q <= '0;
    end else begin
      vld_p1_q  <= vld_p1_d;
      vld_p2_q  <= vld_p2_d;
      act_enc_q <= act_enc_d;
      idx_enc_q <= idx_enc_d;
      nz_cnt_q  <= nz_cnt_d;
      ovf_q     <= ovf_d;
      ovf_cnt_q <= ovf_cnt_d;
    end
  end

  // S1 payload is qualified by vld_p1_q, so it needs no reset
  always_ff @(posedge clk) begin
    mode_p1_q <= mode_p1_d;
    mask_p1_q <= mask_p1_d;
    act_p1_q  <= act_p1_d;
    pos_p1_q  <= pos_p1_d;
  end

  assign out_valid    = vld_p2_q;
  assign act_enc_dout = act_enc_q;
  assign idx_enc_dout = idx_enc_q;
  assign nz_cnt       = nz_cnt_q;
  assign ovf          = ovf_q;
  assign ovf_cnt      = ovf_cnt_q;

endmodule

// File: tb/tb_zeroskip_pipe.sv
// Directed bench for zeroskip_pipe: vector table plus stall, reset and counter sequences.
module tb_zeroskip_pipe;
  localparam int GS = 32, NZ = 16, DW = 8, IW = 5, CW = 5;

  logic clk = 1'b0, rst_n = 1'b0, mode = 1'b0, in_valid = 1'b0;
  logic out_ready = 1'b0, ovf_cnt_clr = 1'b0;
  logic in_ready, out_valid, ovf;
  logic [GS-1:0]          znz_din = '0;
  logic [GS-1:0][DW-1:0]  act_din = '0;
  logic [NZ-1:0][DW-1:0]  act_enc_dout;
  logic [NZ-1:0][IW-1:0]  idx_enc_dout;
  logic [CW-1:0]          nz_cnt;
  logic [15:0]            ovf_cnt;

  int n_cmp = 0, n_err = 0;

  zeroskip_pipe dut (
    .clk(clk), .rst_n(rst_n), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
    .znz_din(znz_din), .act_din(act_din), .out_valid(out_valid), .out_ready(out_ready),
    .act_enc_dout(act_enc_dout), .idx_enc_dout(idx_enc_dout), .nz_cnt(nz_cnt), .ovf(ovf),
    .ovf_cnt_clr(ovf_cnt_clr), .ovf_cnt(ovf_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        m;
    logic [31:0] mask;
    logic [7:0]  base;
    int          nz;
    logic        ov;
    int          idx0;
    int          idxl;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic drive_group(input logic m, input logic [31:0] mask, input logic [7:0] base);
    mode    = m;
    znz_din = mask;
    for (int i = 0; i < GS; i++) act_din[i] = base + 8'(i);
    in_valid = 1'b1;
  endtask

  // Reference: walk the mask in order, filling slots until the limit is hit
  task automatic model(input logic m, input logic [31:0] mask, input logic [7:0] base,
                       output logic [127:0] ea, output logic [79:0] ei,
                       output int k, output logic ov);
    int lim, pc;
    lim = m ? 8 : 16;
    ea = '0; ei = '0; k = 0; pc = 0;
    for (int i = 0; i < GS; i++) begin
      if (mask[i]) begin
        pc++;
        if (k < lim) begin
          ea[k*8 +: 8] = base + 8'(i);
          ei[k*5 +: 5] = 5'(i);
          k++;
        end
      end
    end
    ov = (pc > lim);
  endtask

  task automatic chk_payload(input string tag, input logic m, input logic [31:0] mask,
                             input logic [7:0] base);
    logic [127:0] ea; logic [79:0] ei; int k; logic ov;
    model(m, mask, base, ea, ei, k, ov);
    chk({tag, "_act"}, 128'(act_enc_dout), ea);
    chk({tag, "_idx"}, 128'(idx_enc_dout), 128'(ei));
    chk({tag, "_nz"},  128'(nz_cnt), 128'(k));
    chk({tag, "_ovf"}, 128'(ovf), 128'(ov));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_ovc;
    int sent, rcvd;
    logic prev_stall, fire_in;
    logic [127:0] prev_a, prev_i;
    bit orp[6];
    orp = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    tbl[0] = '{1'b0, 32'h0000_00FF, 8'h01, 8,  1'b0, 0,  7};
    tbl[1] = '{1'b1, 32'hAAAA_AAAA, 8'h10, 8,  1'b1, 1,  15};
    tbl[2] = '{1'b0, 32'hFFFF_FFFF, 8'h40, 16, 1'b1, 0,  15};
    tbl[3] = '{1'b0, 32'h0000_0000, 8'h55, 0,  1'b0, 0,  0};
    tbl[4] = '{1'b1, 32'h8000_0001, 8'h80, 2,  1'b0, 0,  31};
    tbl[5] = '{1'b1, 32'h0F0F_0000, 8'h00, 8,  1'b0, 16, 27};
    tbl[6] = '{1'b0, 32'hFFFF_0000, 8'h20, 16, 1'b0, 16, 31};
    tbl[7] = '{1'b0, 32'h0001_FFFF, 8'hC0, 16, 1'b1, 0,  15};
    tbl[8] = '{1'b1, 32'h0000_01FF, 8'hE0, 8,  1'b1, 0,  7};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_nz_cnt", 128'(nz_cnt), 128'(0));
    chk("rst_ovf", 128'(ovf), 128'(0));
    chk("rst_ovf_cnt", 128'(ovf_cnt), 128'(0));
    chk("rst_act", 128'(act_enc_dout), 128'(0));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));

    // Table: one group at a time, consumer always ready
    out_ready = 1'b1;
    exp_ovc = 0;
    for (int v = 0; v < 9; v++) begin
      @(negedge clk);
      drive_group(tbl[v].m, tbl[v].mask, tbl[v].base);
      #1;
      chk($sformatf("v%0d_in_ready", v), 128'(in_ready), 128'(1));
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", v), 128'(out_valid), 128'(1));
      chk($sformatf("v%0d_nz_hand", v), 128'(nz_cnt), 128'(tbl[v].nz));
      chk($sformatf("v%0d_ovf_hand", v), 128'(ovf), 128'(tbl[v].ov));
      chk($sformatf("v%0d_idx0", v), 128'(idx_enc_dout[0]), 128'(tbl[v].idx0));
      if (tbl[v].nz > 0)
        chk($sformatf("v%0d_idxl", v), 128'(idx_enc_dout[tbl[v].nz-1]), 128'(tbl[v].idxl));
      chk_payload($sformatf("v%0d", v), tbl[v].m, tbl[v].mask, tbl[v].base);
      @(posedge clk);
      #1;
      if (tbl[v].ov) exp_ovc++;
      chk($sformatf("v%0d_ovf_cnt", v), 128'(ovf_cnt), 128'(exp_ovc));
      chk($sformatf("v%0d_drained", v), 128'(out_valid), 128'(0));
    end

    // Stream of 6 groups with a toggling consumer; odd groups use mode 1 and overflow
    sent = 0; rcvd = 0; prev_stall = 1'b0; prev_a = '0; prev_i = '0;
    for (int c = 0; c < 200 && rcvd < 6; c++) begin
      @(negedge clk);
      out_ready = orp[c % 6];
      if (sent < 6) drive_group(sent[0], 32'h3FF << sent, 8'(sent * 32));
      else in_valid = 1'b0;
      #1;
      if (prev_stall) begin
        chk("stall_act_stable", 128'(act_enc_dout), prev_a);
        chk("stall_idx_stable", 128'(idx_enc_dout), prev_i);
        chk("stall_valid_held", 128'(out_valid), 128'(1));
      end
      if (out_ready) chk("stream_in_ready_hi", 128'(in_ready), 128'(1));
      if (!in_ready) chk("stream_in_ready_lo_cause", 128'(out_valid && !out_ready), 128'(1));
      if (out_valid && out_ready) begin
        chk_payload($sformatf("s%0d", rcvd), rcvd[0], 32'h3FF << rcvd, 8'(rcvd * 32));
        if (rcvd[0]) exp_ovc++;
        rcvd++;
      end
      prev_stall = out_valid && !out_ready;
      prev_a = 128'(act_enc_dout);
      prev_i = 128'(idx_enc_dout);
      fire_in = in_valid && in_ready;
      @(posedge clk);
      if (fire_in) sent++;
    end
    chk("stream_all_received", 128'(rcvd), 128'(6));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("stream_ovf_cnt", 128'(ovf_cnt), 128'(exp_ovc));
    chk("stream_no_dup", 128'(out_valid), 128'(0));

    // Fill both stages under stall, then reset asynchronously mid-cycle
    out_ready = 1'b0;
    drive_group(1'b1, 32'hAAAA_AAAA, 8'h10);
    @(posedge clk);
    @(negedge clk);
    drive_group(1'b0, 32'h0000_000F, 8'h50);
    #1;
    chk("fill_in_ready_s1_only", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    chk("fill_in_ready_full", 128'(in_ready), 128'(0));
    chk("fill_out_valid", 128'(out_valid), 128'(1));
    chk("fill_ovf", 128'(ovf), 128'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 128'(out_valid), 128'(0));
    chk("arst_nz_cnt", 128'(nz_cnt), 128'(0));
    chk("arst_ovf", 128'(ovf), 128'(0));
    chk("arst_act", 128'(act_enc_dout), 128'(0));
    chk("arst_ovf_cnt", 128'(ovf_cnt), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("arst_in_ready", 128'(in_ready), 128'(1));
    out_ready = 1'b1;
    @(negedge clk);
    drive_group(1'b0, 32'h0000_0F00, 8'h70);
    @(posedge clk);
    #1;
    chk("post_rst_no_ghost", 128'(out_valid), 128'(0));
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 128'(out_valid), 128'(1));
    chk_payload("post_rst", 1'b0, 32'h0000_0F00, 8'h70);
    @(posedge clk);
    #1;
    chk("post_rst_alone", 128'(out_valid), 128'(0));

    // Saturation from FFFE with three back-to-back overflow groups
    @(negedge clk);
    force dut.ovf_cnt_q = 16'hFFFE;
    #1;
    release dut.ovf_cnt_q;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_group(1'b1, 32'hAAAA_AAAA, 8'h10);
      @(posedge clk);
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("sat_first", 128'(ovf_cnt), 128'(16'hFFFF));
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("sat_hold", 128'(ovf_cnt), 128'(16'hFFFF));
    chk("sat_drained", 128'(out_valid), 128'(0));

    // Clear coinciding with an overflow transfer wins
    @(negedge clk);
    drive_group(1'b1, 32'hAAAA_AAAA, 8'h10);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    chk("clr_ovf_present", 128'(out_valid && ovf), 128'(1));
    ovf_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    ovf_cnt_clr = 1'b0;
    chk("clr_priority", 128'(ovf_cnt), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
